// File: rtl/servant_wb_loader.sv
// ============================================================================
// servant_wb_loader: loads a length-prefixed byte stream into memory over
// Wishbone and holds the CPU in reset until the whole image is written.
// Revision: 1.0
// ============================================================================
`default_nettype none

module servant_wb_loader #(
  parameter logic [31:0] BASE_ADR    = 32'h0000_0000,
  parameter int          MAX_WORDS   = 8192,
  parameter int          ACK_TIMEOUT = 255
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [7:0]  i_rx_data,
  input  logic        i_rx_valid,
  output logic        o_rx_ready,
  output logic [31:0] o_wb_adr,
  output logic [31:0] o_wb_dat,
  output logic [3:0]  o_wb_sel,
  output logic        o_wb_we,
  output logic        o_wb_cyc,
  input  logic        i_wb_ack,
  output logic        o_cpu_rst,
  output logic        o_done,
  output logic        o_err,
  output logic [15:0] o_count
);

  localparam int TW = (ACK_TIMEOUT < 2) ? 1 : $clog2(ACK_TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_LEN   = 3'd0,
    S_DATA  = 3'd1,
    S_WRITE = 3'd2,
    S_DONE  = 3'd3,
    S_ERR   = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic [1:0]    idx_q, idx_d;
  logic [23:0]   buf_q, buf_d;
  logic [15:0]   len_q, len_d;
  logic [31:0]   dat_q, dat_d;
  logic [15:0]   cnt_q, cnt_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [31:0]   w_word;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= S_LEN;
      idx_q   <= '0;
      buf_q   <= '0;
      len_q   <= '0;
      dat_q   <= '0;
      cnt_q   <= '0;
      tmo_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      buf_q   <= buf_d;
      len_q   <= len_d;
      dat_q   <= dat_d;
      cnt_q   <= cnt_d;
      tmo_q   <= tmo_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    buf_d   = buf_q;
    len_d   = len_q;
    dat_d   = dat_q;
    cnt_d   = cnt_q;
    tmo_d   = tmo_q;
    // Fourth byte completes the word directly from the input lane
    w_word  = {i_rx_data, buf_q};
    unique case (state_q)
      S_LEN, S_DATA: begin
        if (i_rx_valid) begin
          idx_d = idx_q + 2'd1;
          case (idx_q)
            2'd0:    buf_d[7:0]   = i_rx_data;
            2'd1:    buf_d[15:8]  = i_rx_data;
            2'd2:    buf_d[23:16] = i_rx_data;
            default: buf_d        = buf_q;
          endcase
          if (idx_q == 2'd3) begin
            if (state_q == S_LEN) begin
              len_d = w_word[15:0];
              if (w_word == 32'd0)
                state_d = S_DONE;
              else if (w_word > 32'(MAX_WORDS))
                state_d = S_ERR;
              else
                state_d = S_DATA;
            end else begin
              dat_d   = w_word;
              tmo_d   = '0;
              state_d = S_WRITE;
            end
          end
        end
      end
      S_WRITE: begin
        if (i_wb_ack) begin
          cnt_d   = cnt_q + 16'd1;
          state_d = ((cnt_q + 16'd1) == len_q) ? S_DONE : S_DATA;
        end else if (tmo_q == TW'(ACK_TIMEOUT - 1)) begin
          state_d = S_ERR;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      default: begin
        state_d = state_q;
      end
    endcase
  end

  assign o_rx_ready = (state_q == S_LEN) || (state_q == S_DATA);
  assign o_wb_cyc   = (state_q == S_WRITE);
  assign o_wb_we    = o_wb_cyc;
  assign o_wb_sel   = 4'hF;
  assign o_wb_adr   = BASE_ADR + {14'd0, cnt_q, 2'b00};
  assign o_wb_dat   = dat_q;
  assign o_done     = (state_q == S_DONE);
  assign o_err      = (state_q == S_ERR);
  assign o_cpu_rst  = (state_q != S_DONE);
  assign o_count    = cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_servant_wb_loader.sv
// ============================================================================
// tb_servant_wb_loader: scoreboard bench for servant_wb_loader.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_servant_wb_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic        rx_ready;
  logic [31:0] wb_adr, wb_dat;
  logic [3:0]  wb_sel;
  logic        wb_we, wb_cyc;
  logic        wb_ack = 1'b0;
  logic        cpu_rst, done, err;
  logic [15:0] count;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [31:0] adr;
    logic [31:0] dat;
    int          cycles;
  } exp_t;
  exp_t exp_q[$];

  int ack_dly = 1;   // cycle of cyc in which ack is high; 0 means never
  int wcnt = 0;
  int cnt = 0;
  int last_run = 0;
  int cyc_seen = 0;
  logic unst = 1'b0;
  logic [31:0] fa = '0, fd = '0;

  servant_wb_loader dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_rx_data  (rx_data),
    .i_rx_valid (rx_valid),
    .o_rx_ready (rx_ready),
    .o_wb_adr   (wb_adr),
    .o_wb_dat   (wb_dat),
    .o_wb_sel   (wb_sel),
    .o_wb_we    (wb_we),
    .o_wb_cyc   (wb_cyc),
    .i_wb_ack   (wb_ack),
    .o_cpu_rst  (cpu_rst),
    .o_done     (done),
    .o_err      (err),
    .o_count    (count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Responder: ack_dly=1 reproduces the mux's registered single-cycle ack
  always @(posedge clk) begin
    if (!rst_n) begin
      wb_ack <= 1'b0;
      wcnt   <= 0;
    end else if (wb_cyc && !wb_ack) begin
      wcnt   <= wcnt + 1;
      wb_ack <= ((wcnt + 1) == ack_dly);
    end else begin
      wb_ack <= 1'b0;
      wcnt   <= 0;
    end
  end

  // Monitor: checks every acknowledged write against the scoreboard
  always @(negedge clk) begin
    if (wb_cyc) begin
      cyc_seen <= cyc_seen + 1;
      cnt      <= cnt + 1;
      if (cnt == 0) begin
        fa <= wb_adr;
        fd <= wb_dat;
      end else if (wb_adr != fa || wb_dat != fd) begin
        unst <= 1'b1;
      end
      if (rx_ready) unst <= 1'b1;
      if (wb_ack) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_write", 64'(wb_adr), 64'hFFFF_FFFF_FFFF_FFFF);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("wr_adr", 64'(wb_adr), 64'(e.adr));
          chk("wr_dat", 64'(wb_dat), 64'(e.dat));
          chk("wr_sel", 64'(wb_sel), 64'hF);
          chk("wr_we", 64'(wb_we), 64'd1);
          chk("wr_cyc_len", 64'(cnt + 1), 64'(e.cycles));
          chk("wr_stable", 64'(unst || rx_ready ||
              (cnt != 0 && (wb_adr != fa || wb_dat != fd))), 64'd0);
        end
      end
    end else begin
      if (cnt != 0) last_run <= cnt;
      cnt  <= 0;
      unst <= 1'b0;
    end
  end

  task automatic send_byte(input logic [7:0] b);
    int k;
    rx_data  = b;
    rx_valid = 1'b1;
    k = 0;
    while (!rx_ready && k < 1000) begin
      @(negedge clk);
      k++;
    end
    if (k >= 1000) chk("rx_ready_timeout", 64'd0, 64'd1);
    @(posedge clk);
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
  endtask

  task automatic wait_end(input string name);
    int k;
    k = 0;
    while (!(done || err) && k < 1000) begin
      @(negedge clk);
      k++;
    end
    if (k >= 1000) chk(name, 64'd0, 64'd1);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    rx_valid = 1'b0;
    repeat (2) @(negedge clk);
    exp_q.delete();
    rst_n = 1'b1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_rx_ready"}, 64'(rx_ready), 64'd1);
    chk({tag, "_cyc"}, 64'(wb_cyc), 64'd0);
    chk({tag, "_we"}, 64'(wb_we), 64'd0);
    chk({tag, "_adr"}, 64'(wb_adr), 64'd0);
    chk({tag, "_dat"}, 64'(wb_dat), 64'd0);
    chk({tag, "_sel"}, 64'(wb_sel), 64'hF);
    chk({tag, "_cpu_rst"}, 64'(cpu_rst), 64'd1);
    chk({tag, "_done"}, 64'(done), 64'd0);
    chk({tag, "_err"}, 64'(err), 64'd0);
    chk({tag, "_count"}, 64'(count), 64'd0);
  endtask

  initial begin
    int seen;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    chk_reset_vals("rst");

    // Two-word image with mux-style ack
    ack_dly = 1;
    exp_q.push_back('{32'h0, 32'h1122_3344, 2});
    exp_q.push_back('{32'h4, 32'hAABB_CCDD, 2});
    send_word(32'd2);
    send_word(32'h1122_3344);
    send_word(32'hAABB_CCDD);
    wait_end("n2_timeout");
    chk("n2_count", 64'(count), 64'd2);
    chk("n2_done", 64'(done), 64'd1);
    chk("n2_cpu_rst", 64'(cpu_rst), 64'd0);
    chk("n2_q_empty", 64'(exp_q.size()), 64'd0);

    // Delayed ack: cyc held for six cycles
    do_reset();
    ack_dly = 5;
    exp_q.push_back('{32'h0, 32'hDEAD_BEEF, 6});
    send_word(32'd1);
    send_word(32'hDEAD_BEEF);
    wait_end("dly_timeout");
    chk("dly_done", 64'(done), 64'd1);
    chk("dly_count", 64'(count), 64'd1);
    chk("dly_q_empty", 64'(exp_q.size()), 64'd0);

    // Empty image
    do_reset();
    ack_dly = 1;
    seen = cyc_seen;
    send_word(32'd0);
    chk("n0_done", 64'(done), 64'd1);
    chk("n0_cpu_rst", 64'(cpu_rst), 64'd0);
    chk("n0_rx_ready", 64'(rx_ready), 64'd0);
    repeat (3) @(negedge clk);
    chk("n0_no_cyc", 64'(cyc_seen - seen), 64'd0);

    // Oversized image, then stray bytes must not be consumed
    do_reset();
    seen = cyc_seen;
    send_word(32'd8193);
    chk("big_err", 64'(err), 64'd1);
    chk("big_rx_ready", 64'(rx_ready), 64'd0);
    chk("big_cpu_rst", 64'(cpu_rst), 64'd1);
    rx_data = 8'h55;
    rx_valid = 1'b1;
    repeat (5) @(negedge clk);
    rx_valid = 1'b0;
    chk("big_still_err", 64'(err), 64'd1);
    chk("big_still_rx_ready", 64'(rx_ready), 64'd0);
    chk("big_no_cyc", 64'(cyc_seen - seen), 64'd0);

    // Truncated N is 1 but the full 32-bit value exceeds the limit
    do_reset();
    send_word(32'h0001_0001);
    chk("wide_err", 64'(err), 64'd1);
    chk("wide_done", 64'(done), 64'd0);

    // Ack never arrives
    do_reset();
    ack_dly = 0;
    send_word(32'd1);
    send_word(32'h0BAD_F00D);
    wait_end("to_timeout");
    @(negedge clk);
    chk("to_err", 64'(err), 64'd1);
    chk("to_count", 64'(count), 64'd0);
    chk("to_run", 64'(last_run), 64'd255);
    chk("to_cyc_low", 64'(wb_cyc), 64'd0);
    chk("to_cpu_rst", 64'(cpu_rst), 64'd1);

    // Reset while the second write is in flight
    do_reset();
    ack_dly = 1;
    exp_q.push_back('{32'h0, 32'h0403_0201, 2});
    send_word(32'd3);
    send_word(32'h0403_0201);
    send_word(32'h0807_0605);
    chk("mid_cyc_high", 64'(wb_cyc), 64'd1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk_reset_vals("mid");
    exp_q.delete();
    exp_q.push_back('{32'h0, 32'hCAFE_0123, 2});
    send_word(32'd1);
    send_word(32'hCAFE_0123);
    wait_end("mid_timeout");
    chk("mid_done", 64'(done), 64'd1);
    chk("mid_count", 64'(count), 64'd1);
    chk("mid_q_empty", 64'(exp_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
